// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the 5-stage MIPS-subset pipeline.
// Holds the IF/ID register, the 32x32 register file, branch/jump resolution,
// load-use and branch-operand hazard detection, and the ID/EX register.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   pc_4_if, instr_if               PC+4 and instruction from fetch
//   wb_we, wb_addr, wb_data         register file write port (writeback)
//   mem_reg_write, mem_dst          destination info of instruction in MEM
//   beq, jr, pc_4_id, offset28      next-PC candidates to fetch (combinational)
//   pc_write, pc_src                fetch stall and next-PC select (combinational)
//   id_ex_*                         registered operands and controls to EX
module id_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_4_if,
   input  logic [31:0] instr_if,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        mem_reg_write,
   input  logic [4:0]  mem_dst,
   output logic [31:0] beq,
   output logic [31:0] jr,
   output logic [3:0]  pc_4_id,
   output logic [27:0] offset28,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic [31:0] id_ex_rs_data,
   output logic [31:0] id_ex_rt_data,
   output logic [31:0] id_ex_imm,
   output logic [4:0]  id_ex_dst,
   output logic        id_ex_reg_write,
   output logic        id_ex_mem_read,
   output logic        id_ex_mem_write,
   output logic        id_ex_alu_src,
   output logic [5:0]  id_ex_funct
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;
   localparam int unsigned NREG = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;

   localparam logic [1:0] SRC_PC4  = 2'b00;
   localparam logic [1:0] SRC_BEQ  = 2'b01;
   localparam logic [1:0] SRC_JR   = 2'b10;
   localparam logic [1:0] SRC_J    = 2'b11;

   typedef struct packed {
      logic [XLEN-1:0] rs_data;
      logic [XLEN-1:0] rt_data;
      logic [XLEN-1:0] imm;
      logic [RW-1:0]   dst;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            alu_src;
      logic [5:0]      funct;
   } id_ex_t;

   logic [XLEN-1:0] ifid_pc4;
   logic [XLEN-1:0] ifid_instr;
   logic [XLEN-1:0] rf [NREG];

   logic [5:0]      op;
   logic [5:0]      funct;
   logic [RW-1:0]   rs;
   logic [RW-1:0]   rt;
   logic [RW-1:0]   rd;
   logic [15:0]     imm16;
   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;

   logic            is_rtype;
   logic            is_jr;
   logic            is_beq;
   logic            is_j;
   logic            reads_rt;
   logic            load_use;
   logic            br_hazard;
   logic            stall;

   id_ex_t          dec;
   id_ex_t          id_ex_q;

   // Field extraction from the IF/ID instruction
   assign op      = ifid_instr[31:26];
   assign rs      = ifid_instr[25:21];
   assign rt      = ifid_instr[20:16];
   assign rd      = ifid_instr[15:11];
   assign funct   = ifid_instr[5:0];
   assign imm16   = ifid_instr[15:0];
   assign imm_ext = {{16{imm16[15]}}, imm16};

   assign is_rtype = (op == OP_RTYPE);
   assign is_jr    = is_rtype && (funct == FN_JR);
   assign is_beq   = (op == OP_BEQ);
   assign is_j     = (op == OP_J);
   assign reads_rt = is_rtype || (op == OP_SW) || is_beq;

   // Register file reads: r0 is hard zero, same-cycle writeback is forwarded
   always_comb begin
      rs_val = '0;
      rt_val = '0;
      if (rs != '0) begin
         if (wb_we && (wb_addr == rs)) rs_val = wb_data;
         else                          rs_val = rf[rs];
      end
      if (rt != '0) begin
         if (wb_we && (wb_addr == rt)) rt_val = wb_data;
         else                          rt_val = rf[rt];
      end
   end

   // Register file storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wb_we && (wb_addr != '0)) begin
         rf[wb_addr] <= wb_data;
      end
   end

   // Hazard detection; register 0 never creates a dependency
   always_comb begin
      load_use  = 1'b0;
      br_hazard = 1'b0;
      if (id_ex_q.mem_read && (id_ex_q.dst != '0)) begin
         load_use = (id_ex_q.dst == rs) || (reads_rt && (id_ex_q.dst == rt));
      end
      if (is_beq || is_jr) begin
         if (id_ex_q.reg_write && (id_ex_q.dst != '0)) begin
            br_hazard = br_hazard || (id_ex_q.dst == rs) ||
                        (is_beq && (id_ex_q.dst == rt));
         end
         if (mem_reg_write && (mem_dst != '0)) begin
            br_hazard = br_hazard || (mem_dst == rs) ||
                        (is_beq && (mem_dst == rt));
         end
      end
   end

   assign stall    = load_use || br_hazard;
   assign pc_write = ~stall;

   // Next-PC select; a stall suppresses redirect so the branch is re-evaluated
   always_comb begin
      pc_src = SRC_PC4;
      if (!stall) begin
         if (is_j)                          pc_src = SRC_J;
         else if (is_jr)                    pc_src = SRC_JR;
         else if (is_beq && (rs_val == rt_val)) pc_src = SRC_BEQ;
      end
   end

   assign pc_4_id  = ifid_pc4[31:28];
   assign offset28 = {ifid_instr[25:0], 2'b00};
   assign beq      = ifid_pc4 + {imm_ext[29:0], 2'b00};
   assign jr       = rs_val;

   // Decode; control-transfer and unknown opcodes become EX bubbles
   always_comb begin
      dec = '0;
      case (op)
         OP_RTYPE: begin
            if (funct != FN_JR) begin
               dec.rs_data   = rs_val;
               dec.rt_data   = rt_val;
               dec.imm       = imm_ext;
               dec.dst       = rd;
               dec.reg_write = 1'b1;
               dec.funct     = funct;
            end
         end
         OP_LW: begin
            dec.rs_data   = rs_val;
            dec.rt_data   = rt_val;
            dec.imm       = imm_ext;
            dec.dst       = rt;
            dec.reg_write = 1'b1;
            dec.mem_read  = 1'b1;
            dec.alu_src   = 1'b1;
            dec.funct     = FN_ADD;
         end
         OP_SW: begin
            dec.rs_data   = rs_val;
            dec.rt_data   = rt_val;
            dec.imm       = imm_ext;
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.funct     = FN_ADD;
         end
         OP_ADDI: begin
            dec.rs_data   = rs_val;
            dec.rt_data   = rt_val;
            dec.imm       = imm_ext;
            dec.dst       = rt;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.funct     = FN_ADD;
         end
         default: dec = '0;
      endcase
   end

   // IF/ID register: stall holds, redirect flushes to NOP keeping pc4
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_pc4   <= '0;
         ifid_instr <= NOP_INSTR;
      end else if (stall) begin
         ifid_pc4   <= ifid_pc4;
         ifid_instr <= ifid_instr;
      end else if (pc_src != SRC_PC4) begin
         ifid_instr <= NOP_INSTR;
      end else begin
         ifid_pc4   <= pc_4_if;
         ifid_instr <= instr_if;
      end
   end

   // ID/EX register: bubble on stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     id_ex_q <= '0;
      else if (stall) id_ex_q <= '0;
      else            id_ex_q <= dec;
   end

   assign id_ex_rs_data   = id_ex_q.rs_data;
   assign id_ex_rt_data   = id_ex_q.rt_data;
   assign id_ex_imm       = id_ex_q.imm;
   assign id_ex_dst       = id_ex_q.dst;
   assign id_ex_reg_write = id_ex_q.reg_write;
   assign id_ex_mem_read  = id_ex_q.mem_read;
   assign id_ex_mem_write = id_ex_q.mem_write;
   assign id_ex_alu_src   = id_ex_q.alu_src;
   assign id_ex_funct     = id_ex_q.funct;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_4_if;
   logic [31:0] instr_if;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        mem_reg_write;
   logic [4:0]  mem_dst;
   logic [31:0] beq;
   logic [31:0] jr;
   logic [3:0]  pc_4_id;
   logic [27:0] offset28;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic [31:0] id_ex_rs_data;
   logic [31:0] id_ex_rt_data;
   logic [31:0] id_ex_imm;
   logic [4:0]  id_ex_dst;
   logic        id_ex_reg_write;
   logic        id_ex_mem_read;
   logic        id_ex_mem_write;
   logic        id_ex_alu_src;
   logic [5:0]  id_ex_funct;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [31:0] NOP = 32'h0000_0000;

   id_stage #(.NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .pc_4_if(pc_4_if), .instr_if(instr_if),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
      .beq(beq), .jr(jr), .pc_4_id(pc_4_id), .offset28(offset28),
      .pc_write(pc_write), .pc_src(pc_src),
      .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
      .id_ex_imm(id_ex_imm), .id_ex_dst(id_ex_dst),
      .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
      .id_ex_mem_write(id_ex_mem_write), .id_ex_alu_src(id_ex_alu_src),
      .id_ex_funct(id_ex_funct)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      mem_reg_write = 1'b0; mem_dst = '0;
   endtask

   task automatic flush();
      quiet();
      instr_if = NOP;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pc_4_if = $urandom; instr_if = $urandom;
      wb_we = 1'(($urandom)); wb_addr = 5'($urandom); wb_data = $urandom;
      mem_reg_write = 1'($urandom); mem_dst = 5'($urandom);
      #2;
      n_total++; if (pc_write !== 1'b1) $display("FAIL rst_pc_write got %b exp 1", pc_write); else n_pass++;
      n_total++; if (pc_src !== 2'b00) $display("FAIL rst_pc_src got %b exp 00", pc_src); else n_pass++;
      n_total++; if ({id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_dst, id_ex_reg_write, id_ex_mem_read,
                      id_ex_mem_write, id_ex_alu_src, id_ex_funct} !== '0)
         $display("FAIL rst_id_ex got nonzero imm=%h dst=%h rw=%b exp all 0", id_ex_imm, id_ex_dst, id_ex_reg_write);
      else n_pass++;
      n_total++; if ({beq, jr, offset28, pc_4_id} !== '0)
         $display("FAIL rst_fetch_outs got beq=%h jr=%h off=%h pc4=%h exp 0", beq, jr, offset28, pc_4_id);
      else n_pass++;
      quiet();
      pc_4_if = 32'h4; instr_if = 32'h2001_0005;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      instr_if = NOP;
      tick();
      n_total++; if (id_ex_imm !== 32'd5) $display("FAIL addi_imm got %h exp 5", id_ex_imm); else n_pass++;
      n_total++; if (id_ex_dst !== 5'd1) $display("FAIL addi_dst got %0d exp 1", id_ex_dst); else n_pass++;
      n_total++; if (id_ex_reg_write !== 1'b1) $display("FAIL addi_rw got %b exp 1", id_ex_reg_write); else n_pass++;
      n_total++; if (id_ex_alu_src !== 1'b1) $display("FAIL addi_alu_src got %b exp 1", id_ex_alu_src); else n_pass++;
      n_total++; if (id_ex_funct !== 6'h20) $display("FAIL addi_funct got %h exp 20", id_ex_funct); else n_pass++;
   endtask

   task automatic test_bypass();
      flush();
      instr_if = 32'h0060_2020;            // add r4,r3,r0
      tick();
      wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF; instr_if = NOP;
      tick();
      n_total++; if (id_ex_rs_data !== 32'hDEAD_BEEF) $display("FAIL byp_rs_data got %h exp deadbeef", id_ex_rs_data); else n_pass++;
      n_total++; if (id_ex_dst !== 5'd4) $display("FAIL byp_dst got %0d exp 4", id_ex_dst); else n_pass++;
      // IF/ID now NOP (rs = r0); a write to r0 must not leak
      wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
      #1;
      n_total++; if (jr !== 32'h0) $display("FAIL r0_bypass got %h exp 0", jr); else n_pass++;
      tick();
      quiet();
      instr_if = 32'h0060_2020;
      tick();
      n_total++; if (jr !== 32'hDEAD_BEEF) $display("FAIL r3_stored got %h exp deadbeef", jr); else n_pass++;
      instr_if = 32'h0000_0020;            // add r0,r0,r0
      tick();
      n_total++; if (jr !== 32'h0) $display("FAIL r0_read got %h exp 0", jr); else n_pass++;
   endtask

   task automatic test_load_use();
      flush();
      instr_if = 32'h8C22_0000;            // lw r2,0(r1)
      tick();
      instr_if = 32'h0042_2820;            // add r5,r2,r2
      tick();
      n_total++; if (id_ex_mem_read !== 1'b1) $display("FAIL lw_mem_read got %b exp 1", id_ex_mem_read); else n_pass++;
      n_total++; if (pc_write !== 1'b0) $display("FAIL lu_pc_write got %b exp 0", pc_write); else n_pass++;
      instr_if = 32'h0000_3020;
      tick();
      n_total++; if (offset28 !== 28'h108_A080) $display("FAIL lu_ifid_held got %h exp 108a080", offset28); else n_pass++;
      n_total++; if ({id_ex_reg_write, id_ex_mem_read, id_ex_dst} !== '0)
         $display("FAIL lu_bubble got rw=%b mr=%b dst=%0d exp 0", id_ex_reg_write, id_ex_mem_read, id_ex_dst);
      else n_pass++;
      n_total++; if (pc_write !== 1'b1) $display("FAIL lu_release got %b exp 1", pc_write); else n_pass++;
      instr_if = NOP;
      tick();
      n_total++; if (id_ex_dst !== 5'd5 || id_ex_reg_write !== 1'b1)
         $display("FAIL lu_add_issue got dst=%0d rw=%b exp 5/1", id_ex_dst, id_ex_reg_write);
      else n_pass++;
   endtask

   task automatic test_branch_taken();
      flush();
      wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
      tick();
      wb_addr = 5'd2;
      tick();
      quiet();
      pc_4_if = 32'h100; instr_if = 32'h1022_0003;   // beq r1,r2,+3
      tick();
      n_total++; if (pc_src !== 2'b01) $display("FAIL br_pc_src got %b exp 01", pc_src); else n_pass++;
      n_total++; if (beq !== 32'h10C) $display("FAIL br_target got %h exp 10c", beq); else n_pass++;
      pc_4_if = 32'h104; instr_if = 32'h0000_3020;
      tick();
      n_total++; if (offset28 !== 28'h0) $display("FAIL br_flush got %h exp 0", offset28); else n_pass++;
      n_total++; if (id_ex_reg_write !== 1'b0 || id_ex_dst !== 5'd0)
         $display("FAIL br_ex_bubble got rw=%b dst=%0d exp 0", id_ex_reg_write, id_ex_dst);
      else n_pass++;
   endtask

   task automatic test_branch_hazard();
      flush();
      instr_if = 32'h2001_0001;            // addi r1,r0,1
      tick();
      pc_4_if = 32'h200; instr_if = 32'h1020_0005;   // beq r1,r0,+5
      tick();
      n_total++; if (pc_write !== 1'b0 || pc_src !== 2'b00)
         $display("FAIL bh_ex_stall got pcw=%b src=%b exp 0/00", pc_write, pc_src);
      else n_pass++;
      mem_reg_write = 1'b1; mem_dst = 5'd1; instr_if = 32'h0000_3020;
      tick();
      n_total++; if (pc_write !== 1'b0) $display("FAIL bh_mem_stall got %b exp 0", pc_write); else n_pass++;
      n_total++; if (offset28 !== 28'h080_0014) $display("FAIL bh_ifid_held got %h exp 0800014", offset28); else n_pass++;
      mem_reg_write = 1'b0; mem_dst = '0;
      wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd1;
      #1;
      n_total++; if (pc_write !== 1'b1 || pc_src !== 2'b00)
         $display("FAIL bh_resolve got pcw=%b src=%b exp 1/00", pc_write, pc_src);
      else n_pass++;
      n_total++; if (beq !== 32'h214) $display("FAIL bh_target got %h exp 214", beq); else n_pass++;
      tick();
      quiet();
   endtask

   task automatic test_jumps();
      flush();
      pc_4_if = 32'h4000_0010; instr_if = 32'h0800_0040;   // j 0x40
      tick();
      n_total++; if (pc_src !== 2'b11) $display("FAIL j_pc_src got %b exp 11", pc_src); else n_pass++;
      n_total++; if (offset28 !== 28'h100) $display("FAIL j_offset got %h exp 100", offset28); else n_pass++;
      n_total++; if (pc_4_id !== 4'h4) $display("FAIL j_pc4 got %h exp 4", pc_4_id); else n_pass++;
      pc_4_if = 32'h4000_0014; instr_if = 32'h0000_3020;
      wb_we = 1'b1; wb_addr = 5'd31; wb_data = 32'h80;
      tick();
      n_total++; if (offset28 !== 28'h0 || pc_4_id !== 4'h4)
         $display("FAIL j_flush got off=%h pc4=%h exp 0/4", offset28, pc_4_id);
      else n_pass++;
      quiet();
      instr_if = 32'h03E0_0008;            // jr r31
      tick();
      n_total++; if (pc_src !== 2'b10) $display("FAIL jr_pc_src got %b exp 10", pc_src); else n_pass++;
      n_total++; if (jr !== 32'h80) $display("FAIL jr_target got %h exp 80", jr); else n_pass++;
      instr_if = 32'h0000_3020;
      tick();
      n_total++; if (offset28 !== 28'h0) $display("FAIL jr_flush got %h exp 0", offset28); else n_pass++;
   endtask

   task automatic test_reset_mid();
      flush();
      instr_if = 32'h0060_2020;            // add r4,r3,r0 ; r3 = deadbeef
      tick();
      n_total++; if (jr !== 32'hDEAD_BEEF) $display("FAIL mid_pre got %h exp deadbeef", jr); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++; if (jr !== 32'h0 || offset28 !== 28'h0) $display("FAIL mid_ifid got jr=%h off=%h exp 0", jr, offset28); else n_pass++;
      n_total++; if (id_ex_reg_write !== 1'b0 || id_ex_dst !== 5'd0)
         $display("FAIL mid_id_ex got rw=%b dst=%0d exp 0", id_ex_reg_write, id_ex_dst);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_total++; if (offset28 !== 28'h180_8080) $display("FAIL mid_load got %h exp 1808080", offset28); else n_pass++;
      n_total++; if (jr !== 32'h0) $display("FAIL mid_rf_clear got %h exp 0", jr); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_load_use();
      test_branch_taken();
      test_branch_hazard();
      test_jumps();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
